// File: rtl/magma_decoder.sv
// Iterative GOST R 34.12-2015 Magma block decryptor, one Feistel round per clock.
// A block is accepted in IDLE, decrypted over 32 RUN cycles, and held in DONE until consumed.
module magma_decoder (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [63:0]  block,
    input  logic [255:0] key,
    output logic [63:0]  decoded,
    output logic         out_valid,
    input  logic         out_ready
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // Each 64-bit constant packs one 4-bit pi-box; entry j sits at bits [4j+3:4j].
    localparam logic [7:0][63:0] PI = {
        64'h2BC96AF43850DE71,
        64'h73AD0B4FC19652E8,
        64'h0E34187BAC296FD5,
        64'hC24BE390D618A5F7,
        64'hB9E35A076F4D128C,
        64'h069C471EDAF2853B,
        64'hF0DB74E1C5A93286,
        64'h1F307D8E9B5A264C
    };

    state_t       state;
    state_t       state_nxt;
    logic [31:0]  a1;
    logic [31:0]  a0;
    logic [255:0] key_q;
    logic [4:0]   r;
    logic [2:0]   kidx;
    logic [31:0]  rkey;
    logic [31:0]  sum;
    logic [31:0]  sub;
    logic [31:0]  gval;
    logic [31:0]  fval;

    // kidx 0 selects K1 (key[255:224]); rounds 8..31 walk the schedule backwards.
    always_comb begin
        kidx = 3'd0;
        if (r < 5'd8) begin
            kidx = r[2:0];
        end else begin
            kidx = 3'd7 - r[2:0];
        end
        rkey = key_q[(7 - kidx) * 32 +: 32];
        sum  = a0 + rkey;
        sub  = '0;
        for (int n = 0; n < 8; n++) begin
            sub[4*n +: 4] = PI[n][4*sum[4*n +: 4] +: 4];
        end
        gval = {sub[20:0], sub[31:21]};
        fval = gval ^ a1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            a1      <= '0;
            a0      <= '0;
            key_q   <= '0;
            r       <= '0;
            decoded <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a1    <= block[63:32];
                        a0    <= block[31:0];
                        key_q <= key;
                        r     <= '0;
                    end
                end
                RUN: begin
                    // The final round skips the swap and writes the result directly.
                    if (r == 5'd31) begin
                        decoded <= {fval, a0};
                        r       <= '0;
                    end else begin
                        a1 <= a0;
                        a0 <= fval;
                        r  <= r + 5'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (r == 5'd31) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: doc/magma_decoder.md
MAGMA_DECODER -- requirements
Module: magma_decoder

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-003 SHALL have port in_valid, input, 1 bit: ciphertext block and key present.
REQ-004 SHALL have port in_ready, output, 1 bit: decoder accepts a new block.
REQ-005 SHALL have port block, input, 64 bits: ciphertext; bits [63:32] = a1, bits [31:0] = a0.
REQ-006 SHALL have port key, input, 256 bits: key; K1 = key[255:224] ... K8 = key[31:0].
REQ-007 SHALL have port decoded, output, 64 bits: plaintext result.
REQ-008 SHALL have port out_valid, output, 1 bit: decoded holds a valid result.
REQ-009 SHALL have port out_ready, input, 1 bit: consumer accepts the result.

Function
REQ-010 SHALL implement GOST R 34.12-2015 Magma decryption, iterative, one round per clock.
REQ-011 SHALL use states IDLE, RUN and DONE.
REQ-012 SHALL have the following transitions:
- IDLE->RUN on in_valid && in_ready.
- RUN->DONE after the 32nd round.
- DONE->IDLE on out_ready.
REQ-013 SHALL drive in_ready=1 only in IDLE.
REQ-014 SHALL drive out_valid=1 only in DONE.
REQ-015 SHALL, on the accept edge, latch block into 32-bit registers a1/a0, latch all 256 key bits, and clear the 5-bit round counter r to 0.
REQ-016 SHALL apply round keys in decryption order: r=0..7 use K1..K8; r=8..31 use K(8-(r mod 8)), i.e. K8..K1 repeated three times.
REQ-017 SHALL compute round function g(k,a) = rotl11(S(a + k mod 2^32)).
REQ-018 SHALL apply S as the eight 4-bit RFC 8891 pi-boxes, pi0 on bits [3:0] through pi7 on bits [31:28].
REQ-019 SHALL, for rounds r=0..30, update (a1,a0) <= (a0, g(Kr,a0) ^ a1).
REQ-020 SHALL, for round r=31, perform no swap and set decoded <= {g(K1,a0) ^ a1, a0}.
REQ-021 SHALL perform round r on the (r+1)-th rising edge after the accept edge.
REQ-022 SHALL have out_valid=1 and decoded valid after the 32nd edge following acceptance, giving latency 32 cycles.
REQ-023 SHALL have a throughput of one block per 34 cycles minimum: accept, 32 rounds, one handshake cycle.
REQ-024 SHALL hold decoded and out_valid stable in DONE while out_ready=0, for unbounded backpressure.
REQ-025 SHALL, on the DONE edge with out_ready=1, return to IDLE with out_valid=0; decoded keeps its last value.
REQ-026 SHALL ignore in_valid, block and key changes during RUN and DONE; the latched key is used for all 32 rounds.
REQ-027 SHALL perform all additions modulo 2^32 with carry out discarded.
REQ-028 SHALL wrap r only via the RUN->DONE transition; r never exceeds 31.
REQ-029 SHALL produce output bit-exact with the inverse of MagmaEncoder for any key and block.

Reset
REQ-030 SHALL, on a rising edge with rst_n=0, go to state IDLE, set in_ready=1, out_valid=0, decoded=64'h0 and r=0, and clear all a1/a0/key registers.
REQ-031 SHALL, when reset occurs mid-RUN or in DONE, discard the operation without emitting out_valid, and accept no input on that edge.
REQ-032 SHALL give reset priority over every handshake when both occur on the same edge.

Verification
REQ-033 SHALL cover the standard vector: key=ffeeddccbbaa99887766554433221100f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff, block=64'h4ee901e5c2d8ca3d, out_ready=1 -> out_valid exactly 32 edges after accept, decoded=64'hfedcba9876543210.
REQ-034 SHALL cover backpressure: the standard vector with out_ready=0 for 10 cycles after out_valid -> decoded and out_valid held constant and in_ready=0 throughout; one-cycle handshake, then IDLE.
REQ-035 SHALL cover input blocking: in_valid held high with a changed block/key during RUN -> result still 64'hfedcba9876543210 and no second accept before return to IDLE.
REQ-036 SHALL cover reset mid-run: rst_n=0 at round 15 -> next cycle out_valid=0, decoded=0, in_ready=1; re-run of the standard vector gives the correct result.
REQ-037 SHALL cover round trip: MagmaEncoder(block=64'h0123456789abcdef, standard key) fed into the decoder -> decoded=64'h0123456789abcdef.
REQ-038 SHALL cover back-to-back operation: two vectors with in_valid held high -> second accept on the cycle after the first handshake, both results correct and in order.
